// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states, request legality.
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } lsu_state_e;

  // Width code in bits [1:0] is shared by signed and unsigned loads, so one alignment rule covers both.
  function automatic logic is_bad(input logic st, input logic [2:0] f3, input logic [1:0] off);
    logic illegal;
    logic mis;
    if (st) illegal = (f3 >= 3'd3);
    else    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    mis = ((f3[1:0] == 2'd1) && off[0]) || ((f3[1:0] == 2'd2) && (off != 2'd0));
    return illegal || mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/half selection with extension, and store lane merge.
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_load = i_word;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_BU:   o_load = {24'd0, w_byte};
      F3_HU:   o_load = {16'd0, w_half};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    o_merge = i_word;
    case (i_funct3)
      F3_B: o_merge[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      F3_H: begin
        if (i_off[1]) o_merge[31:16] = i_wdata[15:0];
        else          o_merge[15:0]  = i_wdata[15:0];
      end
      default: o_merge = i_wdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// RV32I load/store unit over a synchronous-read word RAM; sub-word stores use read-modify-write.
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  output logic                     ready,
  input  logic                     store,
  input  logic [2:0]               funct3,
  input  logic [31:0]              addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     done,
  output logic                     err,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);

  lsu_state_e              r_state;
  lsu_state_e              w_next;
  logic                    r_store;
  logic [2:0]              r_funct3;
  logic [ADDRESS_WIDTH+1:0] r_addr;
  logic [DATA_WIDTH-1:0]   r_wd;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_done;
  logic                    r_err;
  logic                    w_accept;
  logic                    w_bad;
  logic [31:0]             w_load;
  logic [31:0]             w_merge;
  logic                    w_unused_addr;

  assign w_unused_addr = ^addr[31:ADDRESS_WIDTH+2];

  assign w_accept = req && (r_state == ST_IDLE);
  assign w_bad    = is_bad(store, funct3, addr[1:0]);

  assign ready  = (r_state == ST_IDLE);
  assign done   = r_done;
  assign err    = r_err;
  assign rdata  = r_rdata;
  assign mem_we = (r_state == ST_WRITE);
  assign mem_a  = r_addr[ADDRESS_WIDTH+1:2];
  assign mem_wd = r_wd;

  lsu_align u_align (
    .i_funct3 (r_funct3),
    .i_off    (r_addr[1:0]),
    .i_word   (mem_rd),
    .i_wdata  (r_wd),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_bad) w_next = (store && funct3 == F3_W) ? ST_WRITE : ST_READ;
      end
      ST_READ:  w_next = ST_WAIT;
      ST_WAIT:  w_next = r_store ? ST_WRITE : ST_IDLE;
      ST_WRITE: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // r_wd holds the raw store data until WAIT replaces it with the merged word for sub-word stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_store  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wd     <= '0;
      r_rdata  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_accept) begin
        r_store  <= store;
        r_funct3 <= funct3;
        r_addr   <= addr[ADDRESS_WIDTH+1:0];
        r_wd     <= wdata;
        if (w_bad) begin
          r_done <= 1'b1;
          r_err  <= 1'b1;
        end
      end
      case (r_state)
        ST_WAIT: begin
          if (r_store) begin
            r_wd <= w_merge;
          end else begin
            r_rdata <= w_load;
            r_done  <= 1'b1;
          end
        end
        ST_WRITE: r_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a behavioural synchronous RAM.
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_init = 1'b1;
  logic        req = 1'b0;
  logic        ready;
  logic        store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        mem_we;
  logic [9:0]  mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:1023];
  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDRESS_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .store(store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
      mem[4] <= 32'h8899AABB;
      mem_rd <= 32'd0;
    end else begin
      mem_rd <= mem[mem_a];
      if (mem_we) mem[mem_a] <= mem_wd;
    end
  end

  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (!rst) begin
      n_tests++;
      if (err && !done) begin
        n_fail++;
        $display("FAIL err_without_done actual err=%b done=%b required err=0", err, done);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
    logic [9:0]  exp_ma;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input logic e, input int lat, input int wen,
                     input logic [9:0] ma, input logic [31:0] ewd);
    vec_t v;
    v.st = st; v.f3 = f3; v.a = a; v.wd = wd; v.exp_rd = rd; v.exp_err = e;
    v.exp_lat = lat; v.exp_we = wen; v.exp_ma = ma; v.exp_wd = ewd;
    vecs.push_back(v);
  endtask

  // Issues one request, scrambles the inputs after accept, and watches until done (bounded).
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic got, output logic e, output logic rdy,
                       output logic [31:0] rd, output int wen, output logic [9:0] ma,
                       output logic [31:0] swd);
    @(negedge clk);
    store = st; funct3 = f3; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; store = ~st; funct3 = 3'd7; addr = 32'hFFFF_FFFF; wdata = ~wd;
    lat = 0; got = 1'b0; e = 1'b0; rdy = 1'b0; rd = 32'd0; wen = 0; ma = '0; swd = 32'd0;
    for (int k = 0; k < 8 && !got; k++) begin
      if (mem_we) begin
        wen++; ma = mem_a; swd = mem_wd;
      end
      if (done) begin
        got = 1'b1; e = err; rdy = ready; rd = rdata;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
  endtask

  initial begin
    int lat, wen;
    logic got, e, rdy;
    logic [31:0] rd, swd;
    logic [9:0] ma;
    int snap;

    add(0, 3'd0, 32'h11, 0, 32'hFFFFFFAA, 0, 2, 0, 0, 0);
    add(0, 3'd4, 32'h11, 0, 32'h000000AA, 0, 2, 0, 0, 0);
    add(0, 3'd1, 32'h12, 0, 32'hFFFF8899, 0, 2, 0, 0, 0);
    add(0, 3'd5, 32'h12, 0, 32'h00008899, 0, 2, 0, 0, 0);
    add(0, 3'd2, 32'h10, 0, 32'h8899AABB, 0, 2, 0, 0, 0);
    add(0, 3'd0, 32'h13, 0, 32'hFFFFFF88, 0, 2, 0, 0, 0);
    add(0, 3'd4, 32'h10, 0, 32'h000000BB, 0, 2, 0, 0, 0);
    add(1, 3'd0, 32'h12, 32'h000000CC, 32'h000000BB, 0, 3, 1, 10'h004, 32'h88CCAABB);
    add(0, 3'd2, 32'h10, 0, 32'h88CCAABB, 0, 2, 0, 0, 0);
    add(1, 3'd2, 32'h20, 32'hDEADBEEF, 32'h88CCAABB, 0, 1, 1, 10'h008, 32'hDEADBEEF);
    add(0, 3'd2, 32'h20, 0, 32'hDEADBEEF, 0, 2, 0, 0, 0);
    add(0, 3'd2, 32'h22, 0, 32'hDEADBEEF, 1, 0, 0, 0, 0);
    add(0, 3'd1, 32'h13, 0, 32'hDEADBEEF, 1, 0, 0, 0, 0);
    add(1, 3'd1, 32'h11, 32'h1111, 32'hDEADBEEF, 1, 0, 0, 0, 0);
    add(0, 3'd3, 32'h10, 0, 32'hDEADBEEF, 1, 0, 0, 0, 0);
    add(1, 3'd3, 32'h10, 32'h2222, 32'hDEADBEEF, 1, 0, 0, 0, 0);
    add(0, 3'd5, 32'h11, 0, 32'hDEADBEEF, 1, 0, 0, 0, 0);
    add(1, 3'd1, 32'h16, 32'h00001234, 32'hDEADBEEF, 0, 3, 1, 10'h005, 32'h12340000);
    add(0, 3'd5, 32'h16, 0, 32'h00001234, 0, 2, 0, 0, 0);
    add(0, 3'd1, 32'h14, 0, 32'h00000000, 0, 2, 0, 0, 0);
    add(1, 3'd0, 32'h17, 32'h000000F0, 32'h00000000, 0, 3, 1, 10'h005, 32'hF0340000);
    add(0, 3'd0, 32'h17, 0, 32'hFFFFFFF0, 0, 2, 0, 0, 0);
    add(0, 3'd6, 32'h10, 0, 32'hFFFFFFF0, 1, 0, 0, 0, 0);
    add(0, 3'd7, 32'h10, 0, 32'hFFFFFFF0, 1, 0, 0, 0, 0);
    add(1, 3'd4, 32'h10, 32'h3333, 32'hFFFFFFF0, 1, 0, 0, 0, 0);

    // Reset is asserted from time zero, before any clock edge.
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_a", {22'd0, mem_a}, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; ram_init = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd, lat, got, e, rdy, rd, wen, ma, swd);
      if (!got) begin
        n_tests++; n_fail++;
        $display("FAIL vec%0d_timeout actual=no_done required=done", i);
      end else begin
        check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
        check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
        check($sformatf("vec%0d_ready", i), {31'd0, rdy}, 32'd1);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        check($sformatf("vec%0d_we_cycles", i), wen, vecs[i].exp_we);
        if (vecs[i].exp_we > 0) begin
          check($sformatf("vec%0d_mem_a", i), {22'd0, ma}, {22'd0, vecs[i].exp_ma});
          check($sformatf("vec%0d_mem_wd", i), swd, vecs[i].exp_wd);
        end
      end
    end

    // req held high across a busy load: only the edge ending the done cycle accepts again.
    @(negedge clk);
    store = 1'b0; funct3 = 3'd0; addr = 32'h11; req = 1'b1;
    @(posedge clk); #1;
    funct3 = 3'd2; addr = 32'h20;
    @(posedge clk); #1;
    check("b2b_busy_ready", {31'd0, ready}, 32'd0);
    check("b2b_busy_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    check("b2b_first_done", {31'd0, done}, 32'd1);
    check("b2b_first_rdata", rdata, 32'hFFFFFFAA);
    @(posedge clk); #1;
    req = 1'b0;
    check("b2b_second_accepted", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_second_done", {31'd0, done}, 32'd1);
    check("b2b_second_rdata", rdata, 32'hDEADBEEF);

    // Reset mid-SH during WAIT must abort without a write or done pulse.
    @(negedge clk);
    store = 1'b1; funct3 = 3'd1; addr = 32'h10; wdata = 32'h5555; req = 1'b1;
    snap = we_cnt;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_mem_we", {31'd0, mem_we}, 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_mem_a", {22'd0, mem_a}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("postrst_done%0d", k), {31'd0, done}, 32'd0);
    end
    check("midrst_we_cycles", we_cnt - snap, 0);
    do_op(0, 3'd2, 32'h10, 0, lat, got, e, rdy, rd, wen, ma, swd);
    check("postrst_lw_done", {31'd0, got}, 32'd1);
    check("postrst_word4", rd, 32'h88CCAABB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
